// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 link scheduler.
package rs422_pkg;

  localparam int CMD_W         = 32;
  localparam int CNT_W         = 16;
  localparam int CMD_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF   = 1048576;
  localparam int GUARD_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHK_RUN = 2'd1,
    ST_CMD_RUN = 2'd2,
    ST_GUARD   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rs422_link_sched_if.sv
// Request, engine-handshake and status bundle of the RS422 link scheduler.
// master = scheduler side, slave = register slice / engines side.
interface rs422_link_sched_if;
  import rs422_pkg::*;

  logic             cmd_req;
  logic [CMD_W-1:0] cmd_word;
  logic             chk_req;
  logic             err_clr;
  logic             hdlc_tx_done;
  logic             hdlc_rx_done;
  logic             chk_done;
  logic             hdlc_start;
  logic [CMD_W-1:0] hdlc_cmd;
  logic             chk_start;
  logic             abort;
  logic             sel_chk;
  logic             busy;
  logic             cmd_full;
  logic             err_timeout;
  logic             cmd_drop;
  logic [CNT_W-1:0] ok_cnt;

  modport master (
    input  cmd_req, cmd_word, chk_req, err_clr, hdlc_tx_done, hdlc_rx_done, chk_done,
    output hdlc_start, hdlc_cmd, chk_start, abort, sel_chk, busy, cmd_full,
           err_timeout, cmd_drop, ok_cnt
  );

  modport slave (
    output cmd_req, cmd_word, chk_req, err_clr, hdlc_tx_done, hdlc_rx_done, chk_done,
    input  hdlc_start, hdlc_cmd, chk_start, abort, sel_chk, busy, cmd_full,
           err_timeout, cmd_drop, ok_cnt
  );

endinterface

// File: rtl/rs422_cmd_fifo.sv
// Synchronous command FIFO; full is judged before a same-cycle pop,
// so a push into a full FIFO is refused even if a pop happens too.
module rs422_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (cnt_r == (AW+1)'(DEPTH));
  assign empty     = (cnt_r == (AW+1)'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/rs422_link_sched.sv
// RS422 link transaction scheduler: arbitrates self-check vs queued HDLC commands.
// Optional RS422_SCHED_RETRY_EN: one reissue of a command after its first timeout.
module rs422_link_sched
  import rs422_pkg::*;
#(
  parameter int CMD_DEPTH = CMD_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int GUARD     = GUARD_DEF
) (
  input logic                clk,
  input logic                rst,
  rs422_link_sched_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int G_W  = $clog2(GUARD + 1);

  sched_state_e     state_r;
  logic [WD_W-1:0]  wd_r;
  logic [G_W-1:0]   g_cnt_r;
  logic             chk_pend_r;
  logic             tx_seen_r;
  logic             rx_seen_r;
  logic             hdlc_start_r;
  logic [CMD_W-1:0] hdlc_cmd_r;
  logic             chk_start_r;
  logic             abort_r;
  logic             sel_chk_r;
  logic             busy_r;
  logic             err_timeout_r;
  logic             cmd_drop_r;
  logic [CNT_W-1:0] ok_cnt_r;
`ifdef RS422_SCHED_RETRY_EN
  logic             retry_pend_r;
  logic             retry_used_r;
`endif

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CMD_W-1:0] fifo_head_s;
  logic             push_s;
  logic             drop_s;
  logic             pop_s;
  logic             wd_exp_s;
  logic             tx_any_s;
  logic             rx_any_s;
  logic             err_set_s;

  assign push_s   = bus.cmd_req & ~fifo_full_s;
  assign drop_s   = bus.cmd_req & fifo_full_s;
  assign wd_exp_s = (wd_r == WD_W'(TIMEOUT - 1));
  assign tx_any_s = tx_seen_r | bus.hdlc_tx_done;
  assign rx_any_s = rx_seen_r | bus.hdlc_rx_done;

  rs422_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (bus.cmd_word),
    .pop   (pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Head pop: only from IDLE when neither a self-check nor a retry is owed.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == ST_IDLE) begin
`ifdef RS422_SCHED_RETRY_EN
      pop_s = ~chk_pend_r & ~retry_pend_r & ~fifo_empty_s;
`else
      pop_s = ~chk_pend_r & ~fifo_empty_s;
`endif
    end else begin
      pop_s = 1'b0;
    end
  end

  // Timeout that must be reported; a completing strobe at expiry wins.
  always_comb begin
    err_set_s = 1'b0;
    if (state_r == ST_CHK_RUN) begin
      err_set_s = wd_exp_s & ~bus.chk_done;
    end else if (state_r == ST_CMD_RUN) begin
`ifdef RS422_SCHED_RETRY_EN
      err_set_s = wd_exp_s & ~(tx_any_s & rx_any_s) & retry_used_r;
`else
      err_set_s = wd_exp_s & ~(tx_any_s & rx_any_s);
`endif
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Scheduler state machine with registered pulses, flags and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wd_r          <= '0;
      g_cnt_r       <= '0;
      chk_pend_r    <= 1'b0;
      tx_seen_r     <= 1'b0;
      rx_seen_r     <= 1'b0;
      hdlc_start_r  <= 1'b0;
      hdlc_cmd_r    <= '0;
      chk_start_r   <= 1'b0;
      abort_r       <= 1'b0;
      sel_chk_r     <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      cmd_drop_r    <= 1'b0;
      ok_cnt_r      <= '0;
`ifdef RS422_SCHED_RETRY_EN
      retry_pend_r  <= 1'b0;
      retry_used_r  <= 1'b0;
`endif
    end else begin
      hdlc_start_r <= 1'b0;
      chk_start_r  <= 1'b0;
      abort_r      <= 1'b0;

      if (bus.chk_req)                              chk_pend_r <= 1'b1;
      else if (state_r == ST_IDLE && chk_pend_r)    chk_pend_r <= 1'b0;

      if (err_set_s)        err_timeout_r <= 1'b1;
      else if (bus.err_clr) err_timeout_r <= 1'b0;

      if (drop_s)           cmd_drop_r <= 1'b1;
      else if (bus.err_clr) cmd_drop_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (chk_pend_r) begin
            state_r     <= ST_CHK_RUN;
            chk_start_r <= 1'b1;
            sel_chk_r   <= 1'b1;
            busy_r      <= 1'b1;
            wd_r        <= '0;
`ifdef RS422_SCHED_RETRY_EN
          end else if (retry_pend_r) begin
            state_r      <= ST_CMD_RUN;
            hdlc_start_r <= 1'b1;
            busy_r       <= 1'b1;
            wd_r         <= '0;
            tx_seen_r    <= 1'b0;
            rx_seen_r    <= 1'b0;
            retry_pend_r <= 1'b0;
            retry_used_r <= 1'b1;
`endif
          end else if (pop_s) begin
            state_r      <= ST_CMD_RUN;
            hdlc_cmd_r   <= fifo_head_s;
            hdlc_start_r <= 1'b1;
            busy_r       <= 1'b1;
            wd_r         <= '0;
            tx_seen_r    <= 1'b0;
            rx_seen_r    <= 1'b0;
`ifdef RS422_SCHED_RETRY_EN
            retry_used_r <= 1'b0;
`endif
          end
        end
        ST_CHK_RUN: begin
          if (bus.chk_done) begin
            state_r <= ST_GUARD;
            g_cnt_r <= '0;
          end else if (wd_exp_s) begin
            abort_r <= 1'b1;
            state_r <= ST_GUARD;
            g_cnt_r <= '0;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        ST_CMD_RUN: begin
          if (tx_any_s && rx_any_s) begin
            ok_cnt_r <= ok_cnt_r + CNT_W'(1);
            state_r  <= ST_GUARD;
            g_cnt_r  <= '0;
          end else if (wd_exp_s) begin
            abort_r <= 1'b1;
            state_r <= ST_GUARD;
            g_cnt_r <= '0;
`ifdef RS422_SCHED_RETRY_EN
            if (!retry_used_r) retry_pend_r <= 1'b1;
`endif
          end else begin
            wd_r      <= wd_r + WD_W'(1);
            tx_seen_r <= tx_any_s;
            rx_seen_r <= rx_any_s;
          end
        end
        ST_GUARD: begin
          if (g_cnt_r == G_W'(GUARD - 1)) begin
            state_r   <= ST_IDLE;
            sel_chk_r <= 1'b0;
            busy_r    <= 1'b0;
          end else begin
            g_cnt_r <= g_cnt_r + G_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sel_chk_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hdlc_start  = hdlc_start_r;
  assign bus.hdlc_cmd    = hdlc_cmd_r;
  assign bus.chk_start   = chk_start_r;
  assign bus.abort       = abort_r;
  assign bus.sel_chk     = sel_chk_r;
  assign bus.busy        = busy_r;
  assign bus.cmd_full    = fifo_full_s;
  assign bus.err_timeout = err_timeout_r;
  assign bus.cmd_drop    = cmd_drop_r;
  assign bus.ok_cnt      = ok_cnt_r;

endmodule

// File: tb/tb_rs422_link_sched.sv
// Directed bench for rs422_link_sched: dut_a (default timeout) and dut_t (TIMEOUT=64).
// Honours RS422_SCHED_RETRY_EN in the timeout scenario.
module tb_rs422_link_sched;

  logic        clk;
  logic        rst;
  logic        cmd_req;
  logic [31:0] cmd_word;
  logic        chk_req;
  logic        err_clr;
  logic        tx_done;
  logic        rx_done;
  logic        chk_done;

  int checks   = 0;
  int failures = 0;

  bit          ev_kind [8];
  logic [31:0] ev_word [8];
  bit          ev_sel  [8];
  int          ev_cyc  [8];
  int          ev_n;
  bit          full_hist [64];

  rs422_link_sched_if ifa ();
  rs422_link_sched_if ift ();

  assign ifa.cmd_req = cmd_req;   assign ift.cmd_req = cmd_req;
  assign ifa.cmd_word = cmd_word; assign ift.cmd_word = cmd_word;
  assign ifa.chk_req = chk_req;   assign ift.chk_req = chk_req;
  assign ifa.err_clr = err_clr;   assign ift.err_clr = err_clr;
  assign ifa.hdlc_tx_done = tx_done; assign ift.hdlc_tx_done = tx_done;
  assign ifa.hdlc_rx_done = rx_done; assign ift.hdlc_rx_done = rx_done;
  assign ifa.chk_done = chk_done; assign ift.chk_done = chk_done;

  rs422_link_sched #(.CMD_DEPTH(4), .GUARD(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rs422_link_sched #(.CMD_DEPTH(4), .TIMEOUT(64), .GUARD(16)) dut_t (.clk(clk), .rst(rst), .bus(ift));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd_req = 1'b1; cmd_word = w;
    tick();
    cmd_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Drives a push burst and optional chk_req, answers starts 5 cycles later, logs starts of dut_a.
  task automatic run_seq(input int push_n, input logic [31:0] base, input int chk_at, input int ncyc);
    int resp_cnt;
    bit resp_chk;
    resp_cnt = -1; resp_chk = 1'b0; ev_n = 0;
    for (int i = 0; i < 8; i++) begin
      ev_kind[i] = 1'b0; ev_word[i] = 'x; ev_sel[i] = 1'b0; ev_cyc[i] = -1;
    end
    for (int c = 0; c < ncyc; c++) begin
      tx_done = 1'b0; rx_done = 1'b0; chk_done = 1'b0; cmd_req = 1'b0; chk_req = 1'b0;
      if (resp_cnt == 0) begin
        if (resp_chk) chk_done = 1'b1;
        else begin tx_done = 1'b1; rx_done = 1'b1; end
      end
      if (resp_cnt >= 0) resp_cnt--;
      if (c < push_n) begin cmd_req = 1'b1; cmd_word = base + c; end
      if (c == chk_at) chk_req = 1'b1;
      if (ifa.hdlc_start || ifa.chk_start) begin
        if (ev_n < 8) begin
          ev_kind[ev_n] = ifa.chk_start;
          ev_word[ev_n] = ifa.hdlc_cmd;
          ev_sel[ev_n]  = ifa.sel_chk;
          ev_cyc[ev_n]  = c;
        end
        ev_n++;
        resp_cnt = 4;
        resp_chk = ifa.chk_start;
      end
      if (c < 64) full_hist[c] = ifa.cmd_full;
      tick();
    end
    tx_done = 1'b0; rx_done = 1'b0; chk_done = 1'b0; cmd_req = 1'b0; chk_req = 1'b0;
  endtask

  initial begin
    int k;
    int nstart;
    rst = 1'b1; cmd_req = 1'b0; cmd_word = 32'h0; chk_req = 1'b0; err_clr = 1'b0;
    tx_done = 1'b0; rx_done = 1'b0; chk_done = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_busy", ifa.busy, 32'd0);
    check("rst_hdlc_start", ifa.hdlc_start, 32'd0);
    check("rst_hdlc_cmd", ifa.hdlc_cmd, 32'd0);
    check("rst_chk_start", ifa.chk_start, 32'd0);
    check("rst_abort", ifa.abort, 32'd0);
    check("rst_sel_chk", ifa.sel_chk, 32'd0);
    check("rst_cmd_full", ifa.cmd_full, 32'd0);
    check("rst_err_timeout", ifa.err_timeout, 32'd0);
    check("rst_cmd_drop", ifa.cmd_drop, 32'd0);
    check("rst_ok_cnt", ifa.ok_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // Single command
    push(32'hA5A5_0001);
    check("single_start_n1", ifa.hdlc_start, 32'd0);
    tick();
    check("single_start_n2", ifa.hdlc_start, 32'd1);
    check("single_cmd_n2", ifa.hdlc_cmd, 32'hA5A5_0001);
    check("single_busy_n2", ifa.busy, 32'd1);
    tick();
    check("single_start_pulse", ifa.hdlc_start, 32'd0);
    repeat (10) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    repeat (99) tick();
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    check("single_ok_cnt", ifa.ok_cnt, 32'd1);
    check("single_busy_guard", ifa.busy, 32'd1);
    repeat (15) tick();
    check("single_busy_last_guard", ifa.busy, 32'd1);
    tick();
    check("single_busy_low", ifa.busy, 32'd0);
    check("single_cmd_held", ifa.hdlc_cmd, 32'hA5A5_0001);

    // Priority: cmd0, self-check, cmd1, cmd2
    do_reset();
    run_seq(3, 32'hB000_0000, 5, 120);
    check("prio_nev", ev_n, 32'd4);
    check("prio_k0", ev_kind[0], 32'd0);
    check("prio_w0", ev_word[0], 32'hB000_0000);
    check("prio_c0", ev_cyc[0], 32'd2);
    check("prio_k1", ev_kind[1], 32'd1);
    check("prio_sel1", ev_sel[1], 32'd1);
    check("prio_c1", ev_cyc[1], 32'd25);
    check("prio_k2", ev_kind[2], 32'd0);
    check("prio_w2", ev_word[2], 32'hB000_0001);
    check("prio_sel2", ev_sel[2], 32'd0);
    check("prio_c2", ev_cyc[2], 32'd48);
    check("prio_w3", ev_word[3], 32'hB000_0002);
    check("prio_c3", ev_cyc[3], 32'd71);
    check("prio_ok_cnt", ifa.ok_cnt, 32'd3);
    check("prio_sel_idle", ifa.sel_chk, 32'd0);

    // Reset mid-CMD_RUN with one command still queued
    push(32'hC0DE_0000);
    push(32'hC0DE_0001);
    tick();
    check("rmid_busy_pre", ifa.busy, 32'd1);
    check("rmid_ok_pre", ifa.ok_cnt, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rmid_busy", ifa.busy, 32'd0);
    check("rmid_cmd", ifa.hdlc_cmd, 32'd0);
    check("rmid_ok", ifa.ok_cnt, 32'd0);
    check("rmid_abort", ifa.abort, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tx_done = 1'b1; rx_done = 1'b1; tick(); tx_done = 1'b0; rx_done = 1'b0;
    nstart = 0;
    for (int c = 0; c < 30; c++) begin
      if (ifa.hdlc_start) nstart++;
      tick();
    end
    check("rmid_no_start", nstart, 32'd0);
    check("rmid_busy_after", ifa.busy, 32'd0);
    check("rmid_ok_after", ifa.ok_cnt, 32'd0);

    // Overflow: 5 pushes while X0 runs
    push(32'hDEAD_0000);
    run_seq(5, 32'hC000_0000, -1, 200);
    check("ovf_full_c3", full_hist[3], 32'd0);
    check("ovf_full_c4", full_hist[4], 32'd1);
    check("ovf_drop", ifa.cmd_drop, 32'd1);
    check("ovf_nev", ev_n, 32'd5);
    check("ovf_w0", ev_word[0], 32'hDEAD_0000);
    check("ovf_w1", ev_word[1], 32'hC000_0000);
    check("ovf_w4", ev_word[4], 32'hC000_0003);
    check("ovf_ok_cnt", ifa.ok_cnt, 32'd5);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovf_drop_clr", ifa.cmd_drop, 32'd0);

    // Timeout on dut_t
    do_reset();
    push(32'hD00D_0001);
    tick();
    check("to_start", ift.hdlc_start, 32'd1);
    for (k = 1; k <= 200; k++) begin
      tick();
      if (ift.abort) break;
    end
    check("to_abort_delay", k, 32'd64);
`ifdef RS422_SCHED_RETRY_EN
    check("to_err_first", ift.err_timeout, 32'd0);
`else
    check("to_err_first", ift.err_timeout, 32'd1);
`endif
    tick();
    check("to_abort_pulse", ift.abort, 32'd0);
`ifdef RS422_SCHED_RETRY_EN
    for (k = 0; k < 100; k++) begin
      if (ift.hdlc_start) break;
      tick();
    end
    check("retry_start_delay", k, 32'd16);
    check("retry_cmd", ift.hdlc_cmd, 32'hD00D_0001);
    for (k = 1; k <= 200; k++) begin
      tick();
      if (ift.abort) break;
    end
    check("retry_abort_delay", k, 32'd64);
    check("retry_err", ift.err_timeout, 32'd1);
`else
    nstart = 0;
    for (int c = 0; c < 120; c++) begin
      if (ift.hdlc_start) nstart++;
      tick();
    end
    check("to_no_retry", nstart, 32'd0);
    check("to_busy_end", ift.busy, 32'd0);
`endif
    check("to_ok_cnt", ift.ok_cnt, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("to_err_clr", ift.err_timeout, 32'd0);

    // Both done strobes in the expiry cycle
    do_reset();
    push(32'hE000_0002);
    tick();
    check("sim_start", ift.hdlc_start, 32'd1);
    repeat (63) tick();
    tx_done = 1'b1; rx_done = 1'b1; tick(); tx_done = 1'b0; rx_done = 1'b0;
    check("sim_abort", ift.abort, 32'd0);
    check("sim_ok_cnt", ift.ok_cnt, 32'd1);
    check("sim_err", ift.err_timeout, 32'd0);
    check("sim_busy_guard", ift.busy, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
